// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL, MLA, UMULL and SMULL.
// Holds the pipeline with stall while working and pulses done for one cycle with the result.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MLA   = 2'b01;
  localparam logic [1:0] OP_SMULL = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     c_q, c_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     res_lo_q, res_lo_d;
  logic [WIDTH-1:0]     res_hi_q, res_hi_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc_fix;

  // The unsigned negation of the most negative value is its own magnitude.
  assign a_mag   = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_mag   = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign acc_fix = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    c_d      = c_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          c_d   = c;
          acc_d = '0;
          cnt_d = CW'(WIDTH - 1);
          if (op == OP_SMULL) begin
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
          end else begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            neg_d    = 1'b0;
          end
          state_d = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        res_lo_d = acc_fix[WIDTH-1:0] + ((op_q == OP_MLA) ? c_q : '0);
        res_hi_d = (op_q == OP_MUL || op_q == OP_MLA) ? '0 : acc_fix[2*WIDTH-1:WIDTH];
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      c_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      c_q      <= c_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign stall     = (state_q == IDLE && start) || state_q == RUN || state_q == FIX;
  assign done      = (state_q == DONE);
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;

endmodule
